// File: rtl/mm_requant_wb_if.sv
// Row-in / word-out handshake bundle for the requant writeback stage.
// slave is the stage's own view; master is the view of whatever drives it.
interface mm_requant_wb_if #(
    parameter int LANES  = 16,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 14
);
    logic                   in_valid;
    logic [LANES*ACC_W-1:0] in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [LANES*8-1:0]     out_data;
    logic [ADDR_W-1:0]      out_addr;
    logic                   out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/mm_requant_wb.sv
// Requantize 16x24-bit accumulator rows to INT8 and stream addressed words to the output SRAM.
// Optional macro REQUANT_RELU_EN clamps negative results to zero after saturation.
module mm_requant_wb #(
    parameter int LANES      = 16,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int TILE_ROWS  = 16,
    parameter int ROW_TILES  = 32,
    parameter int COL_TILES  = 32,
    parameter int ADDR_W     = 14
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_scale,
    input  logic [4:0]  i_shift,
    mm_requant_wb_if.slave bus,
    output logic        o_busy,
    output logic        o_done
);
    localparam int PROD_W = ACC_W + 17;
    localparam int SUM_W  = PROD_W + 1;
    localparam int OUT_W  = LANES * 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int R_W    = $clog2(TILE_ROWS);
    localparam int CT_W   = $clog2(COL_TILES);
    localparam int RT_W   = $clog2(ROW_TILES);
    localparam int TOTAL  = ROW_TILES * TILE_ROWS * COL_TILES;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-128);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [15:0]          scale_q;
    logic [4:0]           shift_q;
    logic [R_W-1:0]       r_q;
    logic [CT_W-1:0]      ct_q;
    logic [RT_W-1:0]      rt_q;
    logic [ADDR_W-1:0]    out_cnt_q;
    logic                 s1_valid_q, s2_valid_q, done_q;
    logic signed [PROD_W-1:0] s1_prod_q [LANES];
    logic [ADDR_W-1:0]    s1_addr_q, s2_addr_q;
    logic [OUT_W-1:0]     s2_data_q;
    logic [OUT_W-1:0]     data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    addr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    logic                 start_go, in_ready_c, in_hs, pop, last_pop;
    logic [CNT_W:0]       occupancy;
    logic [ADDR_W-1:0]    in_addr;
    logic [OUT_W-1:0]     rq_c;

    function automatic logic [7:0] requant(input logic signed [PROD_W-1:0] p, input logic [4:0] sh);
        logic signed [SUM_W-1:0] rnd;
        logic signed [SUM_W-1:0] sum;
        logic [7:0]              res;
        rnd = '0;
        if (sh != 5'd0) rnd = SUM_W'(1) << (sh - 5'd1);
        sum = SUM_W'(p) + rnd;
        sum = sum >>> sh;
        if (sum > SAT_MAX)      res = 8'h7f;
        else if (sum < SAT_MIN) res = 8'h80;
        else                    res = sum[7:0];
`ifdef REQUANT_RELU_EN
        if (sum[SUM_W-1]) res = 8'h00;
`endif
        return res;
    endfunction

    // Count pipeline occupants too, so every accepted row already owns a FIFO slot.
    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(s1_valid_q) + (CNT_W+1)'(s2_valid_q);
    assign in_hs     = bus.in_valid && in_ready_c;
    assign pop       = bus.out_valid && bus.out_ready;
    assign last_pop  = pop && (state_q == ST_RUN) && (out_cnt_q == ADDR_W'(TOTAL - 1));
    assign in_addr   = (ADDR_W'(rt_q) * ADDR_W'(TILE_ROWS) + ADDR_W'(r_q)) * ADDR_W'(COL_TILES)
                       + ADDR_W'(ct_q);

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        start_go   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    start_go = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready_c = (occupancy < (CNT_W+1)'(FIFO_DEPTH));
                if (last_pop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            scale_q   <= '0;
            shift_q   <= '0;
            r_q       <= '0;
            ct_q      <= '0;
            rt_q      <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= last_pop;
            if (start_go) begin
                scale_q   <= i_scale;
                shift_q   <= i_shift;
                r_q       <= '0;
                ct_q      <= '0;
                rt_q      <= '0;
                out_cnt_q <= '0;
            end else begin
                if (in_hs) begin
                    if (r_q == R_W'(TILE_ROWS - 1)) begin
                        r_q <= '0;
                        if (ct_q == CT_W'(COL_TILES - 1)) begin
                            ct_q <= '0;
                            rt_q <= (rt_q == RT_W'(ROW_TILES - 1)) ? '0 : rt_q + 1'b1;
                        end else begin
                            ct_q <= ct_q + 1'b1;
                        end
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end
                if (pop) out_cnt_q <= last_pop ? '0 : out_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rq_c = '0;
        for (int g = 0; g < LANES; g++) rq_c[g*8 +: 8] = requant(s1_prod_q[g], shift_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            for (int g = 0; g < LANES; g++) s1_prod_q[g] <= '0;
        end else begin
            s1_valid_q <= in_hs;
            s2_valid_q <= s1_valid_q;
            if (in_hs) begin
                s1_addr_q <= in_addr;
                for (int g = 0; g < LANES; g++)
                    s1_prod_q[g] <= PROD_W'($signed(bus.in_data[g*ACC_W +: ACC_W]))
                                    * PROD_W'($signed({1'b0, scale_q}));
            end
            if (s1_valid_q) begin
                s2_data_q <= rq_c;
                s2_addr_q <= s1_addr_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else begin
            if (s2_valid_q) begin
                data_mem[wr_ptr_q] <= s2_data_q;
                addr_mem[wr_ptr_q] <= s2_addr_q;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(s2_valid_q) - CNT_W'(pop);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = data_mem[rd_ptr_q];
    assign bus.out_addr  = addr_mem[rd_ptr_q];
    assign o_busy        = (state_q == ST_RUN);
    assign o_done        = done_q;
endmodule

// File: tb/tb_mm_requant_wb.sv
// Scoreboard bench for mm_requant_wb: a reference requant/address model feeds a queue that is
// drained against every output word handshake.
module tb_mm_requant_wb;
    localparam int LANES  = 16;
    localparam int ACC_W  = 24;
    localparam int ADDR_W = 14;
    localparam int IN_W   = LANES * ACC_W;
    localparam int OUT_W  = LANES * 8;
    localparam int TOTAL  = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] scale = '0;
    logic [4:0]  shift = '0;
    logic        busy, done;

    mm_requant_wb_if #(.LANES(LANES), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    mm_requant_wb dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_scale (scale),
        .i_shift (shift),
        .bus     (bus.slave),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+OUT_W-1:0] exp_q [$];
    int unsigned cur_scale = 0, cur_shift = 0;
    int n_rows = 0, pop_idx = 0, done_cnt = 0;
    int cyc = 0, done_cyc = -1, last_pop_cyc = -2;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [ADDR_W-1:0] addr_log [32];
    logic [OUT_W-1:0]  data_log [32];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d, input int unsigned sc,
                                              input int unsigned sh);
        logic [OUT_W-1:0] res;
        longint p;
        res = '0;
        for (int g = 0; g < LANES; g++) begin
            p = $signed(d[g*ACC_W +: ACC_W]);
            p = p * longint'(sc);
            if (sh > 0) p = p + (longint'(1) << (sh - 1));
            p = p >>> sh;
            if (p > 127) p = 127;
            if (p < -128) p = -128;
`ifdef REQUANT_RELU_EN
            if (p < 0) p = 0;
`endif
            res[g*8 +: 8] = p[7:0];
        end
        return res;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                int r, ct, rt;
                logic [ADDR_W-1:0] a;
                r  = n_rows % 16;
                ct = (n_rows / 16) % 32;
                rt = n_rows / 512;
                a  = ADDR_W'((rt * 16 + r) * 32 + ct);
                exp_q.push_back({a, model(bus.in_data, cur_scale, cur_shift)});
                n_rows = (n_rows + 1) % TOTAL;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    logic [ADDR_W+OUT_W-1:0] e;
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e[OUT_W-1:0]);
                    check("out_addr", bus.out_addr, e[ADDR_W+OUT_W-1:OUT_W]);
                end
                if (pop_idx < 32) begin
                    addr_log[pop_idx] = bus.out_addr;
                    data_log[pop_idx] = bus.out_data;
                end
                pop_idx++;
                last_addr = bus.out_addr;
                if (bus.out_addr == ADDR_W'(TOTAL - 1)) last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        #3 rst_n = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        exp_q.delete();
        n_rows = 0;
        pop_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_start(input int unsigned sc, input int unsigned sh);
        cur_scale = sc;
        cur_shift = sh;
        n_rows = 0;
        pop_idx = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        scale = 16'(sc);
        shift = 5'(sh);
        @(posedge clk);
        #1 start = 1'b0;
        scale = '0;
        shift = '0;
    endtask

    task automatic send_row(input logic [IN_W-1:0] d);
        bit hs;
        int t;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        hs = 0;
        t = 0;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        if (!hs) check("in_timeout", 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] rand_row();
        logic [IN_W-1:0] d;
        for (int g = 0; g < LANES; g++) d[g*ACC_W +: ACC_W] = 24'($urandom);
        return d;
    endfunction

    initial begin
        logic [IN_W-1:0] d;
        int t;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_busy0", busy, 0);
        rst_n = 1'b1;

        // IDLE ignores valid rows
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_in_ready", bus.in_ready, 0);
        check("idle_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;

        // unity scale, latency
        do_start(1, 0);
        check("run_busy", busy, 1);
        for (int g = 0; g < LANES; g++) d[g*ACC_W +: ACC_W] = 24'(5);
        send_row(d);
        @(negedge clk);
        check("lat_c1", bus.out_valid, 0);
        @(negedge clk);
        check("lat_c2", bus.out_valid, 0);
        @(negedge clk);
        check("lat_c3", bus.out_valid, 1);
        check("lat_data", bus.out_data, {16{8'h05}});
        check("lat_addr", bus.out_addr, 0);
        drain();

        // rounding and saturation, scale 3 shift 2
        do_reset();
        check("no_done_after_reset", done_cnt, 0);
        do_start(3, 2);
        d = '0;
        d[0*ACC_W +: ACC_W] = 24'(7);
        d[1*ACC_W +: ACC_W] = 24'(-7);
        d[2*ACC_W +: ACC_W] = 24'(100000);
        d[3*ACC_W +: ACC_W] = 24'(-100000);
        send_row(d);
        drain();
        check("rq_pos7", data_log[0][7:0], 8'h05);
`ifdef REQUANT_RELU_EN
        check("rq_neg7", data_log[0][15:8], 8'h00);
        check("rq_satlo", data_log[0][31:24], 8'h00);
`else
        check("rq_neg7", data_log[0][15:8], 8'hfb);
        check("rq_satlo", data_log[0][31:24], 8'h80);
`endif
        check("rq_sathi", data_log[0][23:16], 8'h7f);

        // address order over 17 rows, plus -7 at unity scale
        do_reset();
        do_start(1, 0);
        for (int i = 0; i < 17; i++) begin
            d = rand_row();
            if (i == 0) d[0 +: ACC_W] = 24'(-7);
            send_row(d);
        end
        drain();
`ifdef REQUANT_RELU_EN
        check("relu_neg7", data_log[0][7:0], 8'h00);
`else
        check("relu_neg7", data_log[0][7:0], 8'hf9);
`endif
        check("addr_row15", addr_log[15], 480);
        check("addr_row16", addr_log[16], 1);

        // backpressure
        do_reset();
        do_start(2, 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_row(rand_row());
        @(negedge clk);
        check("bp_ready_drop", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data = rand_row();
        repeat (10) @(negedge clk);
        check("bp_ready_held", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_sb_depth", exp_q.size(), 4);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_row(bus.in_data);
        for (int i = 0; i < 3; i++) send_row(rand_row());
        drain();

        // full matrix
        do_reset();
        check("done_cnt_pre", done_cnt, 0);
        do_start(5, 3);
        for (int i = 0; i < TOTAL; i++) send_row(rand_row());
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done, 1);
        check("done_busy", busy, 0);
        check("done_last_addr", last_addr, TOTAL - 1);
        @(negedge clk);
        check("done_pulse_1cyc", done, 0);
        check("done_cnt", done_cnt, 1);
        check("done_timing", done_cyc, last_pop_cyc + 1);
        check("full_sb_empty", exp_q.size(), 0);

        // rerun restarts at 0
        do_start(1, 0);
        check("rerun_busy", busy, 1);
        send_row(rand_row());
        send_row(rand_row());
        drain();
        check("rerun_addr0", addr_log[0], 0);
        check("rerun_addr1", addr_log[1], 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
